demux_dispatch_ctrl: RTL and testbench
======================================

// Module: demux_dispatch_ctrl
// PURPOSE
//   Upstream driver for the 1-to-4 demux (demux1_4). Accepts data words over
//   a valid/ready handshake and assigns each word to the next enabled channel
//   in round-robin order. Drives the demux select and data inputs, holding
//   each word stable for a programmable number of cycles.
// PARAMETERS
//   DATA_W       3   width of in_data / out_data (matches demux data width)
//   HOLD_CYCLES  5   cycles each accepted word is presented on out_*; legal >= 1
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous, active-high reset
//   in_valid   in   1       upstream word available
//   in_data    in   DATA_W  upstream word
//   in_ready   out  1       block can accept a word this cycle
//   ch_en      in   4       per-channel enable mask; bit n enables sel==n
//   sel        out  2       demux select, registered
//   out_data   out  DATA_W  demux data input, registered
//   out_valid  out  1       out_data/sel carry a live word
//   busy       out  1       FSM in HOLD
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, sel=0, out_data=0, out_valid=0,
//     busy=0, round-robin pointer ptr=0, hold counter=0.
//   in_ready = (state==IDLE) && (ch_en!=0); decoded from registered state and
//     ch_en only; no combinational path from in_valid.
//   Channel pick: first n with ch_en[n]=1 searching ptr, ptr+1, ... mod 4.
//   FSM:
//     IDLE: on in_valid && in_ready (edge N): out_data<=in_data, sel<=pick,
//       out_valid<=1, busy<=1, cnt<=HOLD_CYCLES-1, ptr<=pick+1 (mod 4, 3 wraps
//       to 0); -> HOLD. Otherwise outputs unchanged, out_valid=0.
//     HOLD: if cnt!=0, cnt<=cnt-1, stay. If cnt==0: out_valid<=0, busy<=0,
//       out_data<=0, sel keeps last value; -> IDLE.
//   Latency: word presented 1 cycle after acceptance edge; out_valid high for
//     exactly HOLD_CYCLES cycles; min word-to-word cadence HOLD_CYCLES+1.
//   out_data is 0 whenever out_valid=0 (demux routes zero when idle).
//   ch_en sampled only at acceptance; changes during HOLD do not affect the
//     current word; ch_en==0 blocks acceptance indefinitely (no word dropped).
//   in_data/in_valid ignored in HOLD (in_ready=0); upstream must hold word.
//   Counter width: $clog2(HOLD_CYCLES)+1 bits, no overflow possible.
//   Reset asserted mid-HOLD aborts the word: outputs return to reset values
//     immediately; after release next word goes to channel 0 (ptr=0).
// TESTING
//   1 Reset: rst=1 with in_valid=1 -> sel=0, out_data=0, out_valid=0,
//     in_ready=0 after release only if ch_en=0; ch_en=4'hF -> in_ready=1.
//   2 Round robin: ch_en=4'hF, in_data=3'd5, in_valid held high ->
//     sel 0,1,2,3,0; each out_valid run 5 cycles, out_data=5, gap 1 cycle.
//   3 Sparse mask: ch_en=4'b1010, three words 3'd1,3'd2,3'd3 -> sel 1,3,1
//     with out_data 1,2,3 respectively.
//   4 Mask zero: ch_en=0, in_valid=1 for 20 cycles -> in_ready=0,
//     out_valid=0; set ch_en=4'b0100 -> word accepted, sel=2.
//   5 Mask change mid-HOLD: accept on sel=0, set ch_en=4'b1000 during HOLD
//     -> current word stays on sel=0 for 5 cycles; next word sel=3.
//   6 Reset mid-HOLD: assert rst on cycle 3 of a sel=2 word -> out_valid=0,
//     out_data=0, sel=0 same cycle; next word after release on sel=0.

Source files
------------

// File: rtl/demux_dispatch_ctrl_if.sv
// rtl/demux_dispatch_ctrl_if.sv - upstream handshake, channel mask and demux drive bundle
interface demux_dispatch_ctrl_if #(
    parameter int DATA_W = 3
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [3:0]        ch_en;
    logic [1:0]        sel;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              busy;

    modport master (
        output in_valid, in_data, ch_en,
        input  in_ready, sel, out_data, out_valid, busy
    );

    modport slave (
        input  in_valid, in_data, ch_en,
        output in_ready, sel, out_data, out_valid, busy
    );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// rtl/demux_dispatch_ctrl.sv - round-robin word dispatcher driving a 1-to-4 demux
module demux_dispatch_ctrl #(
    parameter int DATA_W      = 3,
    parameter int HOLD_CYCLES = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    demux_dispatch_ctrl_if.slave   bus
);
    localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0]        pick;
    logic [1:0]        idx;
    logic              found;
    logic              accept;

    // First enabled channel at or after the round-robin pointer.
    always_comb begin
        pick  = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && bus.ch_en[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && (bus.ch_en != 4'd0);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.sel       = sel_q;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (accept) begin
                    data_d  = bus.in_data;
                    sel_d   = pick;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    ptr_d   = pick + 2'd1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Zero the data so the demux routes nothing while idle; sel is left as-is.
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    data_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb/tb_demux_dispatch_ctrl.sv - self-checking bench for demux_dispatch_ctrl
module tb_demux_dispatch_ctrl;
    localparam int HOLD = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   model_ptr = 0;

    demux_dispatch_ctrl_if #(.DATA_W(3)) bus ();

    demux_dispatch_ctrl #(.DATA_W(3), .HOLD_CYCLES(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_ptr = 0;
    endtask

    // Sends one word, follows it through its hold window and the idle cycle after it.
    task automatic send_word(input logic [2:0] data, input logic [3:0] mask,
                             input logic [3:0] mid_mask, input int mid_at, input string name);
        int         exp_sel;
        int         n;
        logic [1:0] es;
        exp_sel = -1;
        for (int i = 0; i < 4; i++) begin
            int c;
            c = (model_ptr + i) % 4;
            if (exp_sel < 0 && mask[c]) exp_sel = c;
        end
        es = exp_sel[1:0];
        bus.in_data  = data;
        bus.ch_en    = mask;
        bus.in_valid = 1'b1;
        n = 0;
        #1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept_timeout in_ready=%b required 1", name, bus.in_ready);
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        model_ptr = (exp_sel + 1) % 4;
        for (int k = 0; k < HOLD; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.sel, bus.out_data, bus.busy, bus.in_ready} !==
                {1'b1, es, data, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL %s hold%0d valid=%b sel=%0d data=%0d busy=%b rdy=%b required 1 %0d %0d 1 0",
                         name, k, bus.out_valid, bus.sel, bus.out_data, bus.busy, bus.in_ready, es, data);
            end
            if (k == mid_at) bus.ch_en = mid_mask;
        end
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_data, bus.busy, bus.sel, bus.in_ready} !==
            {1'b0, 3'd0, 1'b0, es, (bus.ch_en != 4'd0)}) begin
            errors++;
            $display("FAIL %s idle valid=%b data=%0d busy=%b sel=%0d rdy=%b required 0 0 0 %0d %b",
                     name, bus.out_valid, bus.out_data, bus.busy, bus.sel, bus.in_ready, es, bus.ch_en != 4'd0);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 3'd7;
        bus.ch_en    = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.sel, bus.out_data, bus.out_valid, bus.busy} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs sel=%0d data=%0d valid=%b busy=%b required all 0",
                     bus.sel, bus.out_data, bus.out_valid, bus.busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_mask0 in_ready=%b required 0", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept out_valid=%b required 0", bus.out_valid);
        end
        bus.ch_en = 4'hF;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_maskF in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b0;
        model_ptr = 0;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 5; i++) send_word(3'd5, 4'hF, 4'hF, -1, "round_robin");
    endtask

    task automatic test_sparse_mask();
        do_reset();
        send_word(3'd1, 4'b1010, 4'b1010, -1, "sparse_w1");
        send_word(3'd2, 4'b1010, 4'b1010, -1, "sparse_w2");
        send_word(3'd3, 4'b1010, 4'b1010, -1, "sparse_w3");
    endtask

    task automatic test_mask_zero();
        do_reset();
        bus.ch_en    = 4'd0;
        bus.in_data  = 3'd2;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
                errors++;
                $display("FAIL mask_zero cyc%0d rdy=%b valid=%b required 0 0", i, bus.in_ready, bus.out_valid);
            end
        end
        #1;
        send_word(3'd2, 4'b0100, 4'b0100, -1, "mask_zero_release");
    endtask

    task automatic test_mask_change();
        do_reset();
        send_word(3'd6, 4'hF, 4'b1000, 2, "mask_change_cur");
        send_word(3'd7, 4'b1000, 4'b1000, -1, "mask_change_next");
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        send_word(3'd1, 4'b0010, 4'b0010, -1, "midrst_pre");
        bus.ch_en    = 4'b0100;
        bus.in_data  = 3'd4;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.sel, bus.out_data} !== {1'b1, 2'd2, 3'd4}) begin
            errors++;
            $display("FAIL midrst_word valid=%b sel=%0d data=%0d required 1 2 4",
                     bus.out_valid, bus.sel, bus.out_data);
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_data, bus.sel, bus.busy} !== 7'd0) begin
            errors++;
            $display("FAIL midrst_abort valid=%b data=%0d sel=%0d busy=%b required 0 0 0 0",
                     bus.out_valid, bus.out_data, bus.sel, bus.busy);
        end
        model_ptr = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        send_word(3'd3, 4'hF, 4'hF, -1, "midrst_after");
    endtask

    task automatic test_random();
        logic [3:0] m;
        logic [2:0] d;
        do_reset();
        for (int i = 0; i < 25; i++) begin
            m = 4'($urandom_range(1, 15));
            d = 3'($urandom_range(0, 7));
            send_word(d, m, m, -1, "random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
            #1;
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 3'd0;
        bus.ch_en    = 4'd0;
        test_reset();
        test_round_robin();
        test_sparse_mask();
        test_mask_zero();
        test_mask_change();
        test_reset_mid_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
